demod_ctrl: RTL and testbench

DEMOD_CTRL -- requirements
Module: demod_ctrl

---
 rtl/demod_pkg.sv | 15 +
 rtl/demod_tx_seq.sv | 39 +++
 rtl/demod_ctrl.sv | 127 ++++++++++++
 tb/tb_demod_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared definitions for the demodulator controller: FSM encoding, sync byte, pipeline latency.
// PIPE_LAT is also consumed by the top-level latency budget, so change it here only.
package demod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         PIPE_LAT  = 7;

endpackage

// File: rtl/demod_tx_seq.sv
// Output byte sequencer: presents OUT_BYTES bytes per armed sample, one cycle after arm.
// A new arm while bytes are still pending drops them and flags an overrun event.
module demod_tx_seq #(
  parameter int OUT_BYTES = 2,
  parameter int SEL_W     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [SEL_W-1:0] sel,
  output logic             overrun_evt
);

  logic last;

  assign last = (sel == SEL_W'(OUT_BYTES - 1));
  // Finishing the final byte in the same cycle as a new arm leaves nothing to drop.
  assign overrun_evt = arm && tx_valid && !(tx_ready && last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      sel      <= '0;
    end else if (arm) begin
      tx_valid <= 1'b1;
      sel      <= '0;
    end else if (tx_valid && tx_ready) begin
      if (last) begin
        tx_valid <= 1'b0;
        sel      <= '0;
      end else begin
        sel <= sel + 1'b1;
      end
    end
  end

endmodule

// File: rtl/demod_ctrl.sv
// Demodulator packet controller: merges UART bytes into IQ samples, steps the datapath,
// flushes the pipeline at packet end and sequences output bytes back to the UART.
module demod_ctrl #(
  parameter int         BYTES_PER_SAMPLE = 4,
  parameter int         PIPE_LAT         = demod_pkg::PIPE_LAT,
  parameter int         OUT_BYTES        = 2,
  parameter int         PKT_SAMPLES      = 1024,
  parameter logic [7:0] SYNC_BYTE        = demod_pkg::SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_ready_i,
  output logic       start_o,
  output logic       merge_finished_o,
  output logic [1:0] byte_sel_o,
  output logic       out_sel_o,
  output logic       tx_valid_o,
  output logic       busy_o,
  output logic       overrun_o
);

  import demod_pkg::*;

  localparam int SW    = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
  localparam int FW    = $clog2(PIPE_LAT + 1);
  localparam int SEL_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  state_t           state;
  logic             live;
  logic [SW-1:0]    sample_cnt;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    flush_cnt;
  logic [SEL_W-1:0] tx_sel;
  logic             arm;
  logic             ovr_evt;
  logic             rx_take;
  logic             emit_idle;

  assign rx_take   = live && rx_valid_i;
  assign arm       = merge_finished_o && (fill == FW'(PIPE_LAT));
  // A pulse in flight will arm emission next cycle, so it counts as busy.
  assign emit_idle = !tx_valid_o && !merge_finished_o;
  assign out_sel_o = tx_sel[0];

  demod_tx_seq #(
    .OUT_BYTES (OUT_BYTES),
    .SEL_W     (SEL_W)
  ) u_tx_seq (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .tx_ready    (tx_ready_i),
    .tx_valid    (tx_valid_o),
    .sel         (tx_sel),
    .overrun_evt (ovr_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      live             <= 1'b0;
      start_o          <= 1'b0;
      merge_finished_o <= 1'b0;
      byte_sel_o       <= '0;
      busy_o           <= 1'b0;
      overrun_o        <= 1'b0;
      sample_cnt       <= '0;
      fill             <= '0;
      flush_cnt        <= '0;
    end else begin
      live             <= 1'b1;
      merge_finished_o <= 1'b0;
      if (merge_finished_o && (fill != FW'(PIPE_LAT)))
        fill <= fill + 1'b1;
      if (ovr_evt)
        overrun_o <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rx_take && (rx_data_i == SYNC_BYTE)) begin
            state      <= ST_COLLECT;
            start_o    <= 1'b1;
            busy_o     <= 1'b1;
            byte_sel_o <= '0;
            sample_cnt <= '0;
            fill       <= '0;
            flush_cnt  <= '0;
          end
        end
        ST_COLLECT: begin
          if (rx_take) begin
            if (byte_sel_o == 2'(BYTES_PER_SAMPLE - 1)) begin
              byte_sel_o       <= '0;
              merge_finished_o <= 1'b1;
              if (sample_cnt == SW'(PKT_SAMPLES - 1))
                state <= ST_FLUSH;
              else
                sample_cnt <= sample_cnt + 1'b1;
            end else begin
              byte_sel_o <= byte_sel_o + 2'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (emit_idle) begin
            if (flush_cnt == FW'(PIPE_LAT)) begin
              state   <= ST_DONE;
              start_o <= 1'b0;
            end else begin
              merge_finished_o <= 1'b1;
              flush_cnt        <= flush_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy_o    <= 1'b0;
          overrun_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_ctrl.sv
// Bench for demod_ctrl: random packets against a sample-level expectation, plus directed
// idle-junk, overrun and mid-packet reset scenarios.
module tb_demod_ctrl;

  localparam int         PKT  = 16;
  localparam int         LAT  = 7;
  localparam int         OB   = 2;
  localparam int         BPS  = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic       start_o, merge_finished_o, out_sel_o, tx_valid_o, busy_o, overrun_o;
  logic [1:0] byte_sel_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed activity, accumulated over the whole run; steps take snapshots.
  int merges   = 0;
  int comps    = 0;
  int done_cyc = 0;
  int ovr_cyc  = 0;
  int comp_merge[$];
  int comp_sel[$];

  demod_ctrl #(
    .BYTES_PER_SAMPLE (BPS),
    .PIPE_LAT         (LAT),
    .OUT_BYTES        (OB),
    .PKT_SAMPLES      (PKT),
    .SYNC_BYTE        (SYNC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid_i       (rx_valid),
    .rx_data_i        (rx_data),
    .tx_ready_i       (tx_ready),
    .start_o          (start_o),
    .merge_finished_o (merge_finished_o),
    .byte_sel_o       (byte_sel_o),
    .out_sel_o        (out_sel_o),
    .tx_valid_o       (tx_valid_o),
    .busy_o           (busy_o),
    .overrun_o        (overrun_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (merge_finished_o === 1'b1) merges++;
      if (tx_valid_o === 1'b1 && tx_ready) begin
        comps++;
        comp_merge.push_back(merges);
        comp_sel.push_back(int'(out_sel_o));
      end
      if (busy_o === 1'b1 && start_o === 1'b0) done_cyc++;
      if (overrun_o === 1'b1) ovr_cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic send_sample(input int gapmax, input bit chk);
    for (int b = 0; b < BPS; b++) begin
      repeat ($urandom_range(gapmax, 0)) cyc();
      send_byte(8'($urandom));
      if (chk) begin
        check("byte_sel", 32'(byte_sel_o), 32'((b + 1) % BPS));
        check("merge_pulse", 32'(merge_finished_o), 32'(b == BPS - 1));
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy_o !== 1'b0 && k < budget) begin
      cyc();
      k++;
    end
    check("idle_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic run_random_packet();
    int m0 = merges;
    int c0 = comps;
    int d0 = done_cyc;
    int o0 = ovr_cyc;
    int q0 = comp_sel.size();
    int bad = 0;
    logic [7:0] d;
    repeat (3) begin
      d = 8'($urandom);
      if (d == SYNC) d = 8'h5A;
      repeat ($urandom_range(2, 0)) cyc();
      send_byte(d);
    end
    check("junk_busy", 32'(busy_o), 32'd0);
    send_byte(SYNC);
    check("sync_start", 32'(start_o), 32'd1);
    check("sync_busy", 32'(busy_o), 32'd1);
    check("sync_byte_sel", 32'(byte_sel_o), 32'd0);
    for (int s = 0; s < PKT; s++) begin
      send_sample(2, 1'b1);
      if (s == LAT) check("no_tx_before_fill", 32'(comps - c0), 32'd0);
    end
    repeat (3) send_byte(8'($urandom));
    check("flush_ignores_rx", 32'(byte_sel_o), 32'd0);
    wait_idle(400);
    check("pkt_merges", 32'(merges - m0), 32'(PKT + LAT));
    check("pkt_bytes", 32'(comps - c0), 32'(OB * PKT));
    if (comp_merge.size() > q0)
      check("first_tx_merge", 32'(comp_merge[q0] - m0), 32'(LAT + 1));
    else
      check("first_tx_present", 32'd0, 32'd1);
    for (int i = q0; i < comp_sel.size(); i++)
      if (comp_sel[i] != (i - q0) % OB) bad++;
    check("out_sel_order", 32'(bad), 32'd0);
    check("done_cycles", 32'(done_cyc - d0), 32'd1);
    check("no_overrun", 32'(ovr_cyc - o0), 32'd0);
    check("idle_start", 32'(start_o), 32'd0);
    check("idle_tx_valid", 32'(tx_valid_o), 32'd0);
  endtask

  initial begin
    int c0;
    int o0;
    // Reset state.
    repeat (3) cyc();
    check("rst_start", 32'(start_o), 32'd0);
    check("rst_merge", 32'(merge_finished_o), 32'd0);
    check("rst_byte_sel", 32'(byte_sel_o), 32'd0);
    check("rst_out_sel", 32'(out_sel_o), 32'd0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    rst = 1'b1;
    repeat (2) cyc();

    // Non-sync byte in IDLE is ignored.
    send_byte(8'h3C);
    check("idle_3c_busy", 32'(busy_o), 32'd0);
    check("idle_3c_start", 32'(start_o), 32'd0);
    check("idle_3c_byte_sel", 32'(byte_sel_o), 32'd0);

    run_random_packet();
    run_random_packet();

    // Overrun: stall the transmitter across a merge.
    c0 = comps;
    o0 = ovr_cyc;
    send_byte(SYNC);
    for (int s = 0; s < LAT + 1; s++) send_sample(0, 1'b0);
    repeat (4) cyc();
    check("ovr_first_bytes", 32'(comps - c0), 32'(OB));
    tx_ready = 1'b0;
    send_sample(0, 1'b0);
    cyc();
    check("ovr_armed_valid", 32'(tx_valid_o), 32'd1);
    check("ovr_armed_sel", 32'(out_sel_o), 32'd0);
    check("ovr_not_yet", 32'(overrun_o), 32'd0);
    send_sample(0, 1'b0);
    cyc();
    check("ovr_flag", 32'(overrun_o), 32'd1);
    check("ovr_restart_valid", 32'(tx_valid_o), 32'd1);
    check("ovr_restart_sel", 32'(out_sel_o), 32'd0);
    tx_ready = 1'b1;
    cyc();
    check("ovr_second_byte_sel", 32'(out_sel_o), 32'd1);
    cyc();
    check("ovr_emit_done", 32'(tx_valid_o), 32'd0);
    for (int s = LAT + 3; s < PKT; s++) send_sample(1, 1'b0);
    wait_idle(400);
    // One armed sample was dropped entirely.
    check("ovr_pkt_bytes", 32'(comps - c0), 32'(OB * (PKT - 1)));
    check("ovr_seen", 32'(ovr_cyc - o0 > 0), 32'd1);
    check("ovr_cleared_idle", 32'(overrun_o), 32'd0);

    // Reset mid-sample.
    send_byte(SYNC);
    send_byte(8'h12);
    send_byte(8'h34);
    check("pre_rst_byte_sel", 32'(byte_sel_o), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("midrst_outputs",
          32'({start_o, merge_finished_o, byte_sel_o, out_sel_o, tx_valid_o, busy_o, overrun_o}),
          32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    send_byte(SYNC);
    check("post_rst_busy", 32'(busy_o), 32'd1);
    check("post_rst_byte_sel", 32'(byte_sel_o), 32'd0);
    send_byte(8'h77);
    check("post_rst_byte1", 32'(byte_sel_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
